// File: rtl/mesh_port_arbiter.sv
// Wormhole round-robin arbiter for one mesh output link with a 1-entry registered output stage.
// ack is combinational, out_flit follows 1 cycle later; no ack while the output slot is full and not draining.
module mesh_port_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int FLIT_W  = 34,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*FLIT_W-1:0] flit_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_flit,
  input  logic                      out_ready,
  output logic                      locked,
  output logic [2:0]                owner,
  output logic                      timeout_err
);

  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [2:0]        rr_ptr;
  logic [2:0]        win;
  logic [2:0]        sel;
  logic              any_req;
  logic              slot_free;
  logic              fire;
  logic              accept;
  logic              tail;
  logic [SW-1:0]     stall_cnt;
  logic [FLIT_W-1:0] sel_flit;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (int'(i) == NUM_REQ - 1) ? 3'd0 : i + 3'd1;
  endfunction

  // Scan downwards so the requester closest to rr_ptr overwrites the others.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    win     = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        any_req = 1'b1;
        win     = 3'(idx);
      end
    end
  end

  assign slot_free = ~out_valid | out_ready;
  assign fire      = (TIMEOUT > 0) && (state == BUSY) && (stall_cnt == STALL_MAX);
  assign sel       = (state == BUSY) ? owner : win;
  assign accept    = rst_n && slot_free && !fire && ((state == BUSY) ? req[owner] : any_req);
  assign sel_flit  = flit_in[int'(sel)*FLIT_W +: FLIT_W];
  assign tail      = sel_flit[FLIT_W-2];
  assign ack       = accept ? (NUM_REQ'(1) << sel) : '0;
  assign locked    = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 3'd0;
      owner       <= 3'd0;
      out_valid   <= 1'b0;
      out_flit    <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= fire;

      if (accept) begin
        out_valid <= 1'b1;
        out_flit  <= sel_flit;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Only an absent owner request ages the lock; downstream backpressure does not.
      if (fire) begin
        state     <= IDLE;
        rr_ptr    <= next_idx(owner);
        stall_cnt <= '0;
      end else if (accept) begin
        owner     <= sel;
        stall_cnt <= '0;
        if (tail) begin
          state  <= IDLE;
          rr_ptr <= next_idx(sel);
        end else begin
          state <= BUSY;
        end
      end else if (state == BUSY && !req[owner] && stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
